// File: rtl/imem_fetch.sv
// Instruction memory with a sequential program-load port and a one-deep,
// one-cycle-latency registered fetch response with misaligned/out-of-range faults.
module imem_fetch #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_instr,
  output logic [1:0]        resp_fault,
  input  logic              load_start,
  input  logic [AW-1:0]     load_base,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              loading
);

  typedef enum logic {S_IDLE, S_LOAD} state_t;

  localparam logic [1:0]  FAULT_OK    = 2'b00;
  localparam logic [1:0]  FAULT_ALIGN = 2'b01;
  localparam logic [1:0]  FAULT_RANGE = 2'b10;
  localparam logic [31:0] DEPTH_W     = 32'(DEPTH);

  state_t            r_state;
  logic [AW-1:0]     r_ptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_instr;
  logic [1:0]        r_resp_fault;

  logic              w_accept;
  logic              w_wr;
  logic              w_misaligned;
  logic              w_oor;
  logic [AW-1:0]     w_idx;

  assign req_ready    = (r_state == S_IDLE) && (!r_resp_valid || resp_ready);
  assign w_accept     = req_valid && req_ready;
  assign w_wr         = !rst && (r_state == S_LOAD) && load_valid;
  assign w_misaligned = (req_addr[1:0] != 2'b00);
  assign w_oor        = ({2'b00, req_addr[31:2]} >= DEPTH_W);
  assign w_idx        = req_addr[AW+1:2];

  assign resp_valid = r_resp_valid;
  assign resp_instr = r_resp_instr;
  assign resp_fault = r_resp_fault;
  assign loading    = (r_state == S_LOAD);

  // Storage is deliberately unreset; rst only suppresses a write in its own cycle.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_ptr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_state <= S_LOAD;
            r_ptr   <= load_base;
          end
        end
        S_LOAD: begin
          if (load_valid) begin
            r_ptr <= r_ptr + 1'b1;
            if (load_last) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Writes only happen in LOAD and reads only in IDLE, so a same-cycle
  // load_start + fetch always sees the pre-load contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_instr <= '0;
      r_resp_fault <= FAULT_OK;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      if (w_misaligned) begin
        r_resp_instr <= '0;
        r_resp_fault <= FAULT_ALIGN;
      end else if (w_oor) begin
        r_resp_instr <= '0;
        r_resp_fault <= FAULT_RANGE;
      end else begin
        r_resp_instr <= r_mem[w_idx];
        r_resp_fault <= FAULT_OK;
      end
    end else if (resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

endmodule
